seg7_scan_driver: RTL and testbench

- Display back-end driving the 3-digit multiplexed seven-segment display over the `seg[7:0]` and `en[2:0]` pins.
- Accepts a 10-bit binary value from the core logic via a load strobe.
- Converts the value to BCD with a sequential double-dabble engine, one shift per clock.
- Time-multiplexes the three digits at a rate set by a clock divider.

---
 rtl/seg7_scan_driver_if.sv | 10 +
 rtl/seg7_scan_driver.sv | 202 ++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Host-side load interface of the seven-segment scan driver: value/dp/load in, busy back.
interface seg7_scan_driver_if;
    logic [9:0] value;
    logic [2:0] dp;
    logic       load;
    logic       busy;

    modport master (output value, output dp, output load, input busy);
    modport slave  (input value, input dp, input load, output busy);
endinterface

// File: rtl/seg7_scan_driver.sv
// Three-digit multiplexed seven-segment driver: binary load, sequential
// double-dabble BCD conversion, leading-zero blanking and clock-divided scan.
module seg7_scan_driver #(
    parameter int CLK_DIV  = 1000,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic              cin,
    input  logic              rstn,
    seg7_scan_driver_if.slave host,
    output logic [7:0]        seg,
    output logic [2:0]        en
);
    localparam int               DIV_W      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       LAST_SHIFT = 4'd9;
    localparam logic [6:0]       SEG_DASH   = 7'b0111111;
    localparam logic [6:0]       SEG_BLANK  = 7'b1111111;

    // conversion engine
    logic        busy;
    logic [3:0]  shift_cnt;
    logic [9:0]  bin_sr;
    logic [11:0] bcd_sr;
    logic [2:0]  dp_pend;
    logic        ovf_pend;
    logic [11:0] bcd_adj;
    logic [21:0] shifted;
    logic        done;

    // displayed data and its next-state view
    logic [3:0]  dig_u, dig_t, dig_h;
    logic [2:0]  dp_reg;
    logic        ovf_reg;
    logic [3:0]  dig_u_nxt, dig_t_nxt, dig_h_nxt;
    logic [2:0]  dp_nxt;
    logic        ovf_nxt;

    // scan
    logic [DIV_W-1:0] div;
    logic [1:0]       idx, idx_nxt;
    logic             scan_on;
    logic             tc;
    logic [3:0]       cur_digit;
    logic             cur_dp;
    logic             cur_blank;
    logic [6:0]       cur_seg;

    assign host.busy = busy;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd, bin} left.
    always_comb begin
        bcd_adj = {add3(bcd_sr[11:8]), add3(bcd_sr[7:4]), add3(bcd_sr[3:0])};
        shifted = {bcd_adj[10:0], bin_sr, 1'b0};
        done    = busy && (shift_cnt == LAST_SHIFT);
    end

    // Load capture and the ten-step conversion; loads during a conversion are ignored.
    always_ff @(posedge cin or negedge rstn) begin
        if (!rstn) begin
            busy      <= 1'b0;
            shift_cnt <= 4'd0;
            bin_sr    <= 10'd0;
            bcd_sr    <= 12'd0;
            dp_pend   <= 3'd0;
            ovf_pend  <= 1'b0;
        end else if (busy) begin
            bcd_sr    <= shifted[21:10];
            bin_sr    <= shifted[9:0];
            shift_cnt <= shift_cnt + 4'd1;
            if (done) begin
                busy <= 1'b0;
            end
        end else if (host.load) begin
            bin_sr    <= host.value;
            bcd_sr    <= 12'd0;
            shift_cnt <= 4'd0;
            dp_pend   <= host.dp;
            ovf_pend  <= (host.value > 10'd999);
            busy      <= 1'b1;
        end
    end

    // Next displayed data: the finished conversion replaces digits, dp and overflow together.
    always_comb begin
        dig_u_nxt = dig_u;
        dig_t_nxt = dig_t;
        dig_h_nxt = dig_h;
        dp_nxt    = dp_reg;
        ovf_nxt   = ovf_reg;
        if (done) begin
            dig_u_nxt = shifted[13:10];
            dig_t_nxt = shifted[17:14];
            dig_h_nxt = shifted[21:18];
            dp_nxt    = dp_pend;
            ovf_nxt   = ovf_pend;
        end
    end

    // Displayed data registers.
    always_ff @(posedge cin or negedge rstn) begin
        if (!rstn) begin
            dig_u   <= 4'd0;
            dig_t   <= 4'd0;
            dig_h   <= 4'd0;
            dp_reg  <= 3'd0;
            ovf_reg <= 1'b0;
        end else begin
            dig_u   <= dig_u_nxt;
            dig_t   <= dig_t_nxt;
            dig_h   <= dig_h_nxt;
            dp_reg  <= dp_nxt;
            ovf_reg <= ovf_nxt;
        end
    end

    // Scan index: the first terminal count only lights the display on the units
    // digit, later ones rotate units -> tens -> hundreds.
    always_comb begin
        tc      = (div == DIV_LAST);
        idx_nxt = idx;
        if (tc && scan_on) begin
            idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
    end

    // Clock divider, scan index and the sticky display-enable flag.
    always_ff @(posedge cin or negedge rstn) begin
        if (!rstn) begin
            div     <= '0;
            idx     <= 2'd0;
            scan_on <= 1'b0;
        end else begin
            div <= tc ? '0 : div + DIV_W'(1);
            idx <= idx_nxt;
            if (tc) begin
                scan_on <= 1'b1;
            end
        end
    end

    // Segment pattern for the digit about to be shown, built from next-state data
    // so a conversion finishing on a scan edge is already visible.
    always_comb begin
        case (idx_nxt)
            2'd0: begin
                cur_digit = dig_u_nxt;
                cur_dp    = dp_nxt[0];
                cur_blank = 1'b0;
            end
            2'd1: begin
                cur_digit = dig_t_nxt;
                cur_dp    = dp_nxt[1];
                cur_blank = LZ_BLANK && (dig_h_nxt == 4'd0) && (dig_t_nxt == 4'd0);
            end
            default: begin
                cur_digit = dig_h_nxt;
                cur_dp    = dp_nxt[2];
                cur_blank = LZ_BLANK && (dig_h_nxt == 4'd0);
            end
        endcase
        if (ovf_nxt) begin
            cur_seg = SEG_DASH;
        end else if (cur_blank) begin
            cur_seg = SEG_BLANK;
        end else begin
            cur_seg = encode(cur_digit);
        end
    end

    // Registered pins: seg and en change together, only at a slot boundary.
    always_ff @(posedge cin or negedge rstn) begin
        if (!rstn) begin
            seg <= 8'hFF;
            en  <= 3'b111;
        end else if (tc) begin
            seg <= {~cur_dp, cur_seg};
            en  <= ~(3'b001 << idx_nxt);
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: two instances (blanking on/off)
// driven identically, expected per-digit patterns queued at load time.
module tb_seg7_scan_driver;
    localparam int CLK_DIV = 4;

    logic       cin;
    logic       rstn;
    logic [7:0] seg_a, seg_b;
    logic [2:0] en_a, en_b;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] en;
        logic [7:0] seg_a;
        logic [7:0] seg_b;
    } exp_t;

    exp_t sb[$];

    seg7_scan_driver_if bus_a ();
    seg7_scan_driver_if bus_b ();

    seg7_scan_driver #(.CLK_DIV(CLK_DIV), .LZ_BLANK(1'b1)) dut_a (
        .cin  (cin),
        .rstn (rstn),
        .host (bus_a),
        .seg  (seg_a),
        .en   (en_a)
    );

    seg7_scan_driver #(.CLK_DIV(CLK_DIV), .LZ_BLANK(1'b0)) dut_b (
        .cin  (cin),
        .rstn (rstn),
        .host (bus_b),
        .seg  (seg_b),
        .en   (en_b)
    );

    // free-running clock
    initial cin = 1'b0;
    always #5 cin = ~cin;

    // expected pin pattern for one digit slot, from decimal arithmetic
    function automatic logic [7:0] model_seg(input int v, input logic [2:0] d, input int i, input bit lz);
        logic [6:0] tbl [10];
        int h, t, u, dig;
        bit blank;
        logic [6:0] s;
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        dig = (i == 0) ? u : ((i == 1) ? t : h);
        blank = lz && ((i == 2 && h == 0) || (i == 1 && h == 0 && t == 0));
        if (v > 999)     s = 7'b0111111;
        else if (blank)  s = 7'b1111111;
        else             s = tbl[dig];
        return {~d[i], s};
    endfunction

    // queue expected slots in scan order: units, tens, hundreds
    task automatic push_expect(input int v, input logic [2:0] d);
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e.en    = ~(3'b001 << i);
            e.seg_a = model_seg(v, d, i, 1'b1);
            e.seg_b = model_seg(v, d, i, 1'b0);
            sb.push_back(e);
        end
    endtask

    // drive a one-cycle load on both instances; caller is at a negedge
    task automatic applyStimulus(input int v, input logic [2:0] d, input bit push);
        bus_a.value = 10'(v);  bus_a.dp = d;  bus_a.load = 1'b1;
        bus_b.value = 10'(v);  bus_b.dp = d;  bus_b.load = 1'b1;
        if (push) push_expect(v, d);
        @(negedge cin);
        bus_a.load = 1'b0;
        bus_b.load = 1'b0;
    endtask

    // wait (bounded) for a fresh units slot starting with no conversion in flight
    task automatic wait_units_slot(output bit ok);
        logic [2:0] prev;
        ok = 1'b0;
        prev = en_a;
        for (int c = 0; c < 200; c++) begin
            @(negedge cin);
            if (!bus_a.busy && prev !== 3'b110 && en_a === 3'b110) begin
                ok = 1'b1;
                break;
            end
            prev = en_a;
        end
    endtask

    task automatic test_reset();
        logic [2:0] exp_en;
        logic [7:0] exp_a, exp_b;
        int slot;
        rstn = 1'b0;
        repeat (3) @(negedge cin);
        checks++;
        if ({bus_a.busy, en_a, seg_a} !== {1'b0, 3'b111, 8'hFF})
            $display("[TB] FAIL reset_a: busy=%b en=%b seg=%h, expected busy=0 en=111 seg=ff", bus_a.busy, en_a, seg_a);
        checks++;
        if ({bus_b.busy, en_b, seg_b} !== {1'b0, 3'b111, 8'hFF})
            $display("[TB] FAIL reset_b: busy=%b en=%b seg=%h, expected busy=0 en=111 seg=ff", bus_b.busy, en_b, seg_b);
        errors += ((({bus_a.busy, en_a, seg_a} !== {1'b0, 3'b111, 8'hFF})) ? 1 : 0)
                + ((({bus_b.busy, en_b, seg_b} !== {1'b0, 3'b111, 8'hFF})) ? 1 : 0);
        rstn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge cin);
            if (k < CLK_DIV) begin
                exp_en = 3'b111;  exp_a = 8'hFF;  exp_b = 8'hFF;
            end else begin
                slot   = ((k - CLK_DIV) / CLK_DIV) % 3;
                exp_en = ~(3'b001 << slot);
                exp_a  = (slot == 0) ? 8'b11000000 : 8'hFF;
                exp_b  = 8'b11000000;
            end
            checks++;
            if ({en_a, seg_a} !== {exp_en, exp_a}) begin
                errors++;
                $display("[TB] FAIL reset_scan_a k=%0d: en=%b seg=%b, expected en=%b seg=%b", k, en_a, seg_a, exp_en, exp_a);
            end
            checks++;
            if ({en_b, seg_b} !== {exp_en, exp_b}) begin
                errors++;
                $display("[TB] FAIL reset_scan_b k=%0d: en=%b seg=%b, expected en=%b seg=%b", k, en_b, seg_b, exp_en, exp_b);
            end
        end
    endtask

    task automatic test_conversion();
        int n;
        bit ok;
        exp_t e;
        applyStimulus(123, 3'b010, 1'b1);
        n = 0;
        for (int c = 0; c < 30 && bus_a.busy; c++) begin
            n++;
            @(negedge cin);
        end
        checks++;
        if (n != 10) begin
            errors++;
            $display("[TB] FAIL busy_len_123: busy cycles=%0d, expected 10", n);
        end
        wait_units_slot(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL slot_wait_123: got timeout, expected units slot");
        end
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front();
            checks++;
            if ({en_a, seg_a, seg_b} !== {e.en, e.seg_a, e.seg_b}) begin
                errors++;
                $display("[TB] FAIL digits_123 i=%0d: en=%b seg_a=%b seg_b=%b, expected en=%b seg_a=%b seg_b=%b",
                         i, en_a, seg_a, seg_b, e.en, e.seg_a, e.seg_b);
            end
            repeat (CLK_DIV) @(negedge cin);
        end
    endtask

    task automatic test_blanking_and_overflow();
        int vals [3];
        bit ok;
        exp_t e;
        vals = '{7, 1000, 999};
        foreach (vals[j]) begin
            applyStimulus(vals[j], 3'b000, 1'b1);
            wait_units_slot(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL slot_wait_%0d: got timeout, expected units slot", vals[j]);
            end
            for (int i = 0; i < 3; i++) begin
                e = sb.pop_front();
                checks++;
                if ({en_a, seg_a, seg_b} !== {e.en, e.seg_a, e.seg_b}) begin
                    errors++;
                    $display("[TB] FAIL digits_%0d i=%0d: en=%b seg_a=%b seg_b=%b, expected en=%b seg_a=%b seg_b=%b",
                             vals[j], i, en_a, seg_a, seg_b, e.en, e.seg_a, e.seg_b);
                end
                repeat (CLK_DIV) @(negedge cin);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit ok;
        exp_t e;
        applyStimulus(555, 3'b000, 1'b1);
        @(negedge cin);
        applyStimulus(222, 3'b111, 1'b0);
        n = 0;
        for (int c = 0; c < 30 && bus_a.busy; c++) begin
            n++;
            @(negedge cin);
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("[TB] FAIL busy_len_ignored: remaining busy cycles=%0d, expected 8", n);
        end
        wait_units_slot(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL slot_wait_555: got timeout, expected units slot");
        end
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front();
            checks++;
            if ({en_a, seg_a, seg_b} !== {e.en, e.seg_a, e.seg_b}) begin
                errors++;
                $display("[TB] FAIL digits_555 i=%0d: en=%b seg_a=%b seg_b=%b, expected en=%b seg_a=%b seg_b=%b",
                         i, en_a, seg_a, seg_b, e.en, e.seg_a, e.seg_b);
            end
            repeat (CLK_DIV) @(negedge cin);
        end
        applyStimulus(300, 3'b100, 1'b0);
        for (int c = 0; c < 30 && bus_a.busy; c++) @(negedge cin);
        applyStimulus(42, 3'b001, 1'b1);
        checks++;
        if (bus_a.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_idle_load: busy=%b, expected 1", bus_a.busy);
        end
        wait_units_slot(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL slot_wait_42: got timeout, expected units slot");
        end
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front();
            checks++;
            if ({en_a, seg_a, seg_b} !== {e.en, e.seg_a, e.seg_b}) begin
                errors++;
                $display("[TB] FAIL digits_42 i=%0d: en=%b seg_a=%b seg_b=%b, expected en=%b seg_a=%b seg_b=%b",
                         i, en_a, seg_a, seg_b, e.en, e.seg_a, e.seg_b);
            end
            repeat (CLK_DIV) @(negedge cin);
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        exp_t e;
        applyStimulus(888, 3'b111, 1'b0);
        repeat (4) @(negedge cin);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({bus_a.busy, en_a, seg_a, en_b, seg_b} !== {1'b0, 3'b111, 8'hFF, 3'b111, 8'hFF}) begin
            errors++;
            $display("[TB] FAIL async_reset: busy=%b en_a=%b seg_a=%h en_b=%b seg_b=%h, expected busy=0 en=111 seg=ff",
                     bus_a.busy, en_a, seg_a, en_b, seg_b);
        end
        @(negedge cin);
        rstn = 1'b1;
        push_expect(0, 3'b000);
        wait_units_slot(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL slot_wait_abort: got timeout, expected units slot");
        end
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front();
            checks++;
            if ({en_a, seg_a, seg_b} !== {e.en, e.seg_a, e.seg_b}) begin
                errors++;
                $display("[TB] FAIL digits_abort i=%0d: en=%b seg_a=%b seg_b=%b, expected en=%b seg_a=%b seg_b=%b",
                         i, en_a, seg_a, seg_b, e.en, e.seg_a, e.seg_b);
            end
            repeat (CLK_DIV) @(negedge cin);
        end
    endtask

    // test sequence
    initial begin
        rstn = 1'b0;
        bus_a.value = '0;  bus_a.dp = '0;  bus_a.load = 1'b0;
        bus_b.value = '0;  bus_b.dp = '0;  bus_b.load = 1'b0;
        test_reset();
        test_conversion();
        test_blanking_and_overflow();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // guard against a stuck run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
